// File: rtl/traffic_pkg.sv
// Shared phase codes, widths and duration lookup for the traffic phase sequencer
// and the display controller that consumes cur_phase / seven_num.
package traffic_pkg;

    localparam int PHASE_W = 3;
    localparam int DIGIT_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        PED_WALK  = 3'd0,
        PED_FLASH = 3'd1,
        PED_CLEAR = 3'd2,
        CAR_GO    = 3'd3,
        CAR_WARN  = 3'd4
    } phase_e;

    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PED_WALK:  return PED_FLASH;
            PED_FLASH: return PED_CLEAR;
            PED_CLEAR: return CAR_GO;
            CAR_GO:    return CAR_WARN;
            CAR_WARN:  return PED_WALK;
            default:   return PED_CLEAR;
        endcase
    endfunction

    function automatic logic [DIGIT_W-1:0] phase_dur(
        input phase_e ph,
        input int     t_walk,
        input int     t_flash,
        input int     t_clear,
        input int     t_go,
        input int     t_warn
    );
        case (ph)
            PED_WALK:  return DIGIT_W'(t_walk);
            PED_FLASH: return DIGIT_W'(t_flash);
            PED_CLEAR: return DIGIT_W'(t_clear);
            CAR_GO:    return DIGIT_W'(t_go);
            CAR_WARN:  return DIGIT_W'(t_warn);
            default:   return DIGIT_W'(t_clear);
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_tick_prescaler.sv
// Divides clk down to a one-cycle registered tick every TICK_DIV cycles;
// clear holds the count at 0 so the next tick is a full period away.
module tick_prescaler #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Phase FSM, per-phase countdown and pedestrian request latch. The request path
// and CAR_GO shortening exist only when TRAFFIC_PED_REQ_EN is defined.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int T_WALK   = 9,
    parameter int T_FLASH  = 5,
    parameter int T_CLEAR  = 2,
    parameter int T_GO     = 9,
    parameter int T_WARN   = 3,
    parameter int PED_CUT  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ped_req,
    input  logic               hold,
    output logic [PHASE_W-1:0] cur_phase,
    output logic [DIGIT_W-1:0] seven_num,
    output logic               tick,
    output logic               ped_pending
);

    if (T_WALK < 1 || T_WALK > 9 || T_FLASH < 1 || T_FLASH > 9 ||
        T_CLEAR < 1 || T_CLEAR > 9 || T_GO < 1 || T_GO > 9 ||
        T_WARN < 1 || T_WARN > 9 || PED_CUT < 1 || PED_CUT > 9 ||
        PED_CUT >= T_GO) begin : g_bad_param
        $error("traffic_phase_sequencer: durations must be 1..9 and PED_CUT < T_GO");
    end

    localparam logic [DIGIT_W-1:0] PED_CUT_D = DIGIT_W'(PED_CUT);
    localparam logic [DIGIT_W-1:0] ONE_D     = DIGIT_W'(1);

    phase_e             phase_q, phase_d;
    logic [DIGIT_W-1:0] num_q, num_d;
    logic               tick_w;
    logic               pend_q;
    logic               walk_entry;
    logic               cut_en;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (hold),
        .tick  (tick_w)
    );

    assign walk_entry = !hold && tick_w && (phase_q == CAR_WARN) && (num_q == ONE_D);

`ifdef TRAFFIC_PED_REQ_EN
    logic [2:0] sync_q, sync_d;
    logic       pend_d;

    always_comb begin
        sync_d = {sync_q[1:0], ped_req};
        pend_d = pend_q;
        // Requests during the pedestrian phases are already being served.
        if (sync_q[1] && !sync_q[2] && phase_q != PED_WALK && phase_q != PED_FLASH)
            pend_d = 1'b1;
        if (walk_entry)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            pend_q <= pend_d;
        end
    end

    assign cut_en = pend_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign pend_q         = 1'b0;
    assign cut_en         = 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        num_d   = num_q;
        // Illegal codes recover to PED_CLEAR so cars never see a stale go.
        if (phase_q > CAR_WARN) begin
            phase_d = PED_CLEAR;
            num_d   = DIGIT_W'(T_CLEAR);
        end else if (!hold && tick_w) begin
            if (num_q > ONE_D) begin
                num_d = num_q - 1'b1;
                if (cut_en && phase_q == CAR_GO && num_q > PED_CUT_D)
                    num_d = PED_CUT_D;
            end else begin
                phase_d = next_phase(phase_q);
                num_d   = phase_dur(phase_d, T_WALK, T_FLASH, T_CLEAR, T_GO, T_WARN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= CAR_GO;
            num_q   <= DIGIT_W'(T_GO);
        end else begin
            phase_q <= phase_d;
            num_q   <= num_d;
        end
    end

    assign cur_phase   = phase_q;
    assign seven_num   = num_q;
    assign tick        = tick_w;
    assign ped_pending = pend_q;

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

- Sequences the intersection's phase cycle and drives the `cur_phase` / `seven_num` inputs of `DisplayController`.
- Divides the 25 MHz clock down to a 1 s tick.
- Runs a per-phase countdown and advances through five fixed phases.
- Optionally shortens the car-go phase when a pedestrian request button is pressed.

## Interface
Parameters:
- `TICK_DIV`, 25000000: clock cycles per countdown tick.
- `T_WALK`, 9: PED_WALK duration in ticks.
- `T_FLASH`, 5: PED_FLASH duration in ticks.
- `T_CLEAR`, 2: PED_CLEAR duration in ticks.
- `T_GO`, 9: CAR_GO duration in ticks.
- `T_WARN`, 3: CAR_WARN duration in ticks.
- `PED_CUT`, 3: remaining CAR_GO ticks after a pedestrian request cuts the phase short.
- All `T_*` and `PED_CUT` are 1..9 (single display digit), with `PED_CUT` < `T_GO`. Any violation is an elaboration error.

Ports:
- `clk`  in  1: 25 MHz clock.
- `rst`  in  1: asynchronous, active-low reset.
- `ped_req`  in  1: pedestrian button, asynchronous level.
- `hold`  in  1: freeze sequencing, synchronous level.
- `cur_phase`  out  3: current phase code.
- `seven_num`  out  4: seconds remaining in the phase (binary 1..9).
- `tick`  out  1: one-cycle pulse at each countdown tick.
- `ped_pending`  out  1: latched, not-yet-served pedestrian request.

## Operation
- Phase codes (cycle order): PED_WALK=0, PED_FLASH=1, PED_CLEAR=2, CAR_GO=3, CAR_WARN=4, then back to PED_WALK. Codes 5–7 are illegal.
- Prescaler:
  - Counts 0..TICK_DIV-1; `tick`=1 when the count equals TICK_DIV-1, and the count wraps to 0 on the next edge.
  - Held at 0 with `tick`=0 while `hold`=1, so the first tick after release comes a full TICK_DIV cycles later.
- Countdown, on `tick`:
  - If `seven_num` > 1: decrement.
  - If `seven_num` == 1: advance `cur_phase` and load `seven_num` with the next phase's `T_*`.
  - Each phase therefore displays T..1 for exactly T ticks.
- Illegal phase (5–7): on the next clock edge, regardless of `tick`, force PED_CLEAR with `seven_num`=T_CLEAR.
- `hold`=1: `cur_phase` and `seven_num` frozen. `ped_req` edges are still latched.
- Reset values: `cur_phase`=3 (CAR_GO), `seven_num`=T_GO, `tick`=0, `ped_pending`=0, prescaler=0, synchronizer flops=0.

## Timing
- `ped_req` path: 2-flop synchronizer, then rising-edge detect. `ped_pending` sets 3 cycles after the edge on `ped_req`.
- `ped_pending` clears on the clock edge that enters PED_WALK.
  - A set and a clear in the same cycle: the clear wins.
  - Edges seen while in PED_WALK or PED_FLASH are ignored.
- `cur_phase` and `seven_num` are registered. They update on the edge where `tick`=1 is sampled, so there is zero extra latency after `tick`.
- `tick` is registered from the prescaler compare.
- Reset asserted mid-phase returns all state to the reset values immediately (asynchronous). Sequencing restarts from CAR_GO on the first clock after deassertion.

## Configuration
- Macro: `TRAFFIC_PED_REQ_EN`.
- Defined: pedestrian shortening is active.
  - On a `tick` in CAR_GO with `ped_pending`=1 and `seven_num` > PED_CUT, `seven_num` loads PED_CUT instead of decrementing.
  - If `seven_num` ≤ PED_CUT, the normal decrement applies.
- Not defined:
  - `ped_req` is unused; the synchronizer and latch are not built.
  - `ped_pending` is tied to 0.
  - CAR_GO always runs the full T_GO ticks.

## Structure
- Shared package `traffic_pkg`:
  - Phase code constants (PED_WALK..CAR_WARN).
  - Phase width (3) and digit width (4) constants.
  - A function returning the duration for a phase code; `DisplayController` reuses the phase constants.
- One sub-module: `tick_prescaler`, parameter `TICK_DIV`, inputs `clk`/`rst`/`clear`, output `tick`. The top block holds the phase FSM, the countdown and the request latch.

## Test plan
All scenarios use `TICK_DIV`=4 and default durations.
- Reset release, no stimulus: `cur_phase` 3→4→0→1→2→3 over 9+3+9+5+2 ticks. `seven_num` counts 9..1, 3..1, 9..1, 5..1, 2..1. `tick` period is 4 cycles.
- With `TRAFFIC_PED_REQ_EN`, pulse `ped_req` while CAR_GO shows 7:
  - `ped_pending`=1 three cycles later.
  - On the next tick, `seven_num`=3, then 2, 1, then phase 4.
  - `ped_pending` clears on entry to phase 0.
- Pulse `ped_req` while CAR_GO shows 2: no cut; 1 follows, then phase 4. A second pulse during PED_WALK leaves `ped_pending`=0.
- Assert `hold` for 20 cycles in PED_FLASH showing 4: outputs frozen and no `tick`. After release, the first `tick` arrives 4 cycles later and `seven_num`=3.
- Force `cur_phase`=6: next edge shows `cur_phase`=2 and `seven_num`=2.
- Assert `rst`=0 mid-PED_WALK, off a clock edge: outputs return immediately to phase 3 / 9 / 0 / 0. Without the macro, a `ped_req` toggle never changes `ped_pending` or the CAR_GO length.
